// File: rtl/jedro_1_mem_arbiter_pkg.sv
// Shared types for the jedro_1 memory-side arbiter.
// Holds the arbiter FSM and owner encodings plus the byte-enable width.
package jedro_1_defines;

  localparam int MEM_BE_WIDTH = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/jedro_1_mem_arbiter_if.sv
// Single-port memory bus: request/grant address phase, rvalid response phase.
// The master drives the request and the slave answers with gnt and rvalid/rdata/err.
interface jedro_1_mem_arbiter_if
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH = 32
) ();

  logic                    req;
  logic                    we;
  logic [MEM_BE_WIDTH-1:0] be;
  logic [DATA_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    gnt;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/jedro_1_mem_arbiter_watchdog.sv
// Response watchdog: counts cycles while enabled and flags the last allowed cycle.
// timeout_o is combinational from the count, so the owner sees it in the TIMEOUT-th cycle.
module jedro_1_arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt <= '0;
    end else if (clr_i) begin
      wd_cnt <= '0;
    end else if (en_i && (wd_cnt != WD_W'(TIMEOUT - 1))) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign timeout_o = en_i && (wd_cnt == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// Serialises the fetch and load/store ports onto one memory bus, one transaction in flight.
// Req to rvalid is 3 cycles with a zero-wait slave; masters stall on gnt, the slave stalls via gnt/rvalid.
module jedro_1_mem_arbiter
  import jedro_1_defines::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  jedro_1_mem_arbiter_if.slave  instr_bus,
  jedro_1_mem_arbiter_if.slave  data_bus,
  jedro_1_mem_arbiter_if.master mem_bus
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q;

  logic any_req;
  logic wd_expire;
  logic wd_timeout;
  logic rsp_done;
  logic arb_fire;

  assign any_req    = instr_bus.req || data_bus.req;
  assign wd_timeout = wd_expire && !mem_bus.rvalid;
  assign rsp_done   = (state_q == ARB_RSP) && (mem_bus.rvalid || wd_expire);
  assign arb_fire   = any_req && ((state_q == ARB_IDLE) || rsp_done);

  // Data normally wins; a full streak with a waiting fetch hands the bus to the fetch.
  assign owner_d = (data_bus.req &&
                    !(instr_bus.req && (streak_q == STREAK_W'(MAX_DATA_STREAK))))
                   ? OWNER_DATA : OWNER_INSTR;

  jedro_1_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     ((state_q == ARB_ADDR) && mem_bus.gnt),
    .en_i      (state_q == ARB_RSP),
    .timeout_o (wd_expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (any_req)     state_d = ARB_ADDR;
      ARB_ADDR: if (mem_bus.gnt) state_d = ARB_RSP;
      ARB_RSP:  if (rsp_done)    state_d = any_req ? ARB_ADDR : ARB_IDLE;
      default:                   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= OWNER_DATA;
    end else if (arb_fire) begin
      owner_q <= owner_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !instr_bus.req) begin
      streak_q <= '0;
    end else if (arb_fire) begin
      if (owner_d == OWNER_INSTR) begin
        streak_q <= '0;
      end else if (streak_q != STREAK_W'(MAX_DATA_STREAK)) begin
        streak_q <= streak_q + STREAK_W'(1);
      end
    end
  end

  always_comb begin
    mem_bus.req      = 1'b0;
    mem_bus.we       = 1'b0;
    mem_bus.be       = '0;
    mem_bus.addr     = '0;
    mem_bus.wdata    = '0;
    instr_bus.gnt    = 1'b0;
    instr_bus.rvalid = 1'b0;
    instr_bus.rdata  = '0;
    instr_bus.err    = 1'b0;
    data_bus.gnt     = 1'b0;
    data_bus.rvalid  = 1'b0;
    data_bus.rdata   = '0;
    data_bus.err     = 1'b0;
    case (state_q)
      ARB_ADDR: begin
        mem_bus.req = 1'b1;
        if (owner_q == OWNER_INSTR) begin
          mem_bus.be    = '1;
          mem_bus.addr  = instr_bus.addr;
          instr_bus.gnt = mem_bus.gnt;
        end else begin
          mem_bus.we    = data_bus.we;
          mem_bus.be    = data_bus.be;
          mem_bus.addr  = data_bus.addr;
          mem_bus.wdata = data_bus.wdata;
          data_bus.gnt  = mem_bus.gnt;
        end
      end
      ARB_RSP: begin
        // A watchdog expiry looks like an error response with zero data.
        if (owner_q == OWNER_INSTR) begin
          instr_bus.rvalid = mem_bus.rvalid || wd_timeout;
          instr_bus.rdata  = mem_bus.rvalid ? mem_bus.rdata : '0;
          instr_bus.err    = (mem_bus.rvalid && mem_bus.err) || wd_timeout;
        end else begin
          data_bus.rvalid  = mem_bus.rvalid || wd_timeout;
          data_bus.rdata   = mem_bus.rvalid ? mem_bus.rdata : '0;
          data_bus.err     = (mem_bus.rvalid && mem_bus.err) || wd_timeout;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Directed bench for jedro_1_mem_arbiter with hand-computed expectations.
module tb_jedro_1_mem_arbiter;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk_i = ~clk_i;

  jedro_1_mem_arbiter_if #(.DATA_WIDTH(32)) ib ();
  jedro_1_mem_arbiter_if #(.DATA_WIDTH(32)) db ();
  jedro_1_mem_arbiter_if #(.DATA_WIDTH(32)) mb ();

  jedro_1_mem_arbiter #(
    .DATA_WIDTH      (32),
    .MAX_DATA_STREAK (4),
    .TIMEOUT         (64)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .instr_bus (ib),
    .data_bus  (db),
    .mem_bus   (mb)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       seen;
    logic [5:0] instr_slot;

    ib.req = 0; ib.we = 0; ib.be = '0; ib.addr = '0; ib.wdata = '0;
    db.req = 0; db.we = 0; db.be = '0; db.addr = '0; db.wdata = '0;
    mb.gnt = 0; mb.rvalid = 0; mb.rdata = '0; mb.err = 0;

    // Reset state
    tick(); tick(); settle();
    chk("rst_mem_req", 32'(mb.req), 0);
    chk("rst_mem_be", 32'(mb.be), 0);
    chk("rst_mem_addr", mb.addr, 0);
    chk("rst_gnts", {30'd0, ib.gnt, db.gnt}, 0);
    chk("rst_rvalids", {30'd0, ib.rvalid, db.rvalid}, 0);
    rst_i = 0;

    // Single fetch
    tick(); ib.req = 1; ib.addr = 32'h100; settle();
    chk("f_c0_mem_req", 32'(mb.req), 0);
    tick(); mb.gnt = 1; settle();
    chk("f_c1_mem_req", 32'(mb.req), 1);
    chk("f_c1_addr", mb.addr, 32'h100);
    chk("f_c1_be", 32'(mb.be), 32'hF);
    chk("f_c1_we", 32'(mb.we), 0);
    chk("f_c1_igNt", 32'(ib.gnt), 1);
    chk("f_c1_dgnt", 32'(db.gnt), 0);
    tick(); ib.req = 0; mb.gnt = 0; mb.rvalid = 1; mb.rdata = 32'hDEADBEEF; settle();
    chk("f_c2_irvalid", 32'(ib.rvalid), 1);
    chk("f_c2_irdata", ib.rdata, 32'hDEADBEEF);
    chk("f_c2_ierr", 32'(ib.err), 0);
    chk("f_c2_drvalid", 32'(db.rvalid), 0);
    tick(); mb.rvalid = 0; settle();
    chk("f_c3_irvalid", 32'(ib.rvalid), 0);
    chk("f_c3_mem_req", 32'(mb.req), 0);

    // Contention: store first, then fetch
    tick();
    ib.req = 1; ib.addr = 32'h104;
    db.req = 1; db.we = 1; db.be = 4'b0001; db.addr = 32'h200; db.wdata = 32'hAA;
    settle();
    tick(); mb.gnt = 1; settle();
    chk("c_st_we", 32'(mb.we), 1);
    chk("c_st_be", 32'(mb.be), 32'h1);
    chk("c_st_addr", mb.addr, 32'h200);
    chk("c_st_wdata", mb.wdata, 32'hAA);
    chk("c_st_gnts", {30'd0, ib.gnt, db.gnt}, 32'h1);
    tick(); db.req = 0; db.we = 0; db.be = '0; mb.gnt = 0; mb.rvalid = 1; mb.rdata = 0; settle();
    chk("c_st_rvalids", {30'd0, ib.rvalid, db.rvalid}, 32'h1);
    tick(); mb.rvalid = 0; mb.gnt = 1; settle();
    chk("c_f_addr", mb.addr, 32'h104);
    chk("c_f_we_be", {27'd0, mb.we, mb.be}, 32'hF);
    chk("c_f_wdata", mb.wdata, 0);
    chk("c_f_gnts", {30'd0, ib.gnt, db.gnt}, 32'h2);
    tick(); ib.req = 0; mb.gnt = 0; mb.rvalid = 1; mb.rdata = 32'h12345678; settle();
    chk("c_f_rvalids", {30'd0, ib.rvalid, db.rvalid}, 32'h2);
    chk("c_f_rdata", ib.rdata, 32'h12345678);
    tick(); mb.rvalid = 0; settle();
    chk("c_idle", 32'(mb.req), 0);

    // Starvation: 4 data grants, then the fetch, then data again
    instr_slot = 6'b010000;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 0) begin
        ib.req = 1; ib.addr = 32'h108;
        db.req = 1; db.we = 0; db.addr = 32'h300;
        mb.gnt = 1; mb.rvalid = 1; mb.rdata = 32'h0BAD0BAD;
      end
      if (k == 10) ib.req = 0;
      settle();
      if (k % 2 == 1) begin
        chk($sformatf("s_gnt_%0d", k), {30'd0, ib.gnt, db.gnt},
            instr_slot[k/2] ? 32'h2 : 32'h1);
      end else if (k > 0) begin
        chk($sformatf("s_rv_%0d", k), {30'd0, ib.rvalid, db.rvalid},
            (k == 10) ? 32'h2 : 32'h1);
      end
    end
    tick(); db.req = 0; mb.gnt = 0; settle();
    chk("s_last_rv", {30'd0, ib.rvalid, db.rvalid}, 32'h1);
    tick(); mb.rvalid = 0; settle();
    chk("s_idle", 32'(mb.req), 0);

    // Timeout on a load
    tick(); db.req = 1; db.addr = 32'h400; mb.rdata = 32'hFFFFFFFF; settle();
    tick(); mb.gnt = 1; settle();
    chk("t_dgnt", 32'(db.gnt), 1);
    seen = 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (i == 0) begin db.req = 0; mb.gnt = 0; end
      settle();
      seen = seen | db.rvalid | ib.rvalid;
    end
    chk("t_quiet", 32'(seen), 0);
    tick(); settle();
    chk("t_rvalid", 32'(db.rvalid), 1);
    chk("t_err", 32'(db.err), 1);
    chk("t_rdata", db.rdata, 0);
    chk("t_irvalid", 32'(ib.rvalid), 0);
    tick(); mb.rvalid = 1; mb.rdata = 32'h5555; settle();
    chk("t_late_rv", {30'd0, ib.rvalid, db.rvalid}, 0);
    chk("t_late_rdata", db.rdata, 0);
    tick(); mb.rvalid = 0; settle();

    // Bus error on a load
    tick(); db.req = 1; db.addr = 32'h500; settle();
    tick(); mb.gnt = 1; settle();
    chk("e_dgnt", 32'(db.gnt), 1);
    tick(); db.req = 0; mb.gnt = 0; mb.rvalid = 1; mb.err = 1; mb.rdata = 32'hCAFE0000; settle();
    chk("e_rvalid", 32'(db.rvalid), 1);
    chk("e_err", 32'(db.err), 1);
    chk("e_rdata", db.rdata, 32'hCAFE0000);
    tick(); mb.rvalid = 0; mb.err = 0; settle();
    chk("e_after", {29'd0, mb.req, db.rvalid, db.err}, 0);

    // Reset while a load waits in RSP
    tick(); db.req = 1; db.addr = 32'h600; settle();
    tick(); mb.gnt = 1; settle();
    chk("r_dgnt", 32'(db.gnt), 1);
    tick(); db.req = 0; mb.gnt = 0; settle();
    chk("r_wait", 32'(db.rvalid), 0);
    tick(); rst_i = 1; settle();
    tick(); rst_i = 0; mb.rvalid = 1; mb.rdata = 32'h77; settle();
    chk("r_rvalid", {30'd0, ib.rvalid, db.rvalid}, 0);
    chk("r_rdata", db.rdata, 0);
    chk("r_mem", {27'd0, mb.req, mb.be}, 0);
    chk("r_gnts", {30'd0, ib.gnt, db.gnt}, 0);
    tick(); mb.rvalid = 0; settle();

    // Bus still works after the reset
    tick(); ib.req = 1; ib.addr = 32'h700; settle();
    tick(); mb.gnt = 1; settle();
    chk("p_addr", mb.addr, 32'h700);
    chk("p_igNt", 32'(ib.gnt), 1);
    tick(); ib.req = 0; mb.gnt = 0; mb.rvalid = 1; mb.rdata = 32'h13579BDF; settle();
    chk("p_rdata", ib.rdata, 32'h13579BDF);
    tick(); mb.rvalid = 0; settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jedro_1_mem_arbiter.md
# jedro_1_mem_arbiter

Two-master to one-slave memory arbiter on the core's memory side. It takes the core's instruction-fetch read port and its load/store read-write port and serialises both onto a single-port memory bus, so the core can run from one shared RAM. It supports one outstanding transaction at a time, uses data-priority arbitration with an anti-starvation limit, and has a response watchdog.

## Interface
Parameters:
- DATA_WIDTH, 32, data and address width
- MAX_DATA_STREAK, 4, maximum consecutive data grants while an instruction request waits
- TIMEOUT, 64, cycles in RSP without mem_rvalid_i before an error is returned

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- instr_req_i  in  1  fetch request; held until instr_gnt_o
- instr_addr_i  in  DATA_WIDTH  fetch address
- instr_gnt_o  out  1  fetch request accepted by memory
- instr_rvalid_o  out  1  fetch response valid, one-cycle pulse
- instr_rdata_o  out  DATA_WIDTH  fetch data
- instr_err_o  out  1  bus error or timeout; qualified by instr_rvalid_o
- data_req_i  in  1  load/store request; held until data_gnt_o
- data_we_i  in  1  1 = store
- data_be_i  in  4  byte enables
- data_addr_i  in  DATA_WIDTH  address
- data_wdata_i  in  DATA_WIDTH  store data
- data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o  out  1/1/DATA_WIDTH/1  as on the instruction side
- mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/1/4/DATA_WIDTH/DATA_WIDTH  slave request
- mem_gnt_i  in  1  slave accepted request
- mem_rvalid_i, mem_rdata_i, mem_err_i  in  1/DATA_WIDTH/1  slave response

## Operation
- FSM states:
  - IDLE: no owner.
  - ADDR: owner's request driven on mem_*; wait for mem_gnt_i.
  - RSP: wait for mem_rvalid_i.
- IDLE → ADDR when any request is present. The owner is registered on entry to ADDR.
- ADDR → RSP on mem_gnt_i.
- RSP → ADDR on mem_rvalid_i or timeout if any request is pending (a new arbitration happens in the same cycle); otherwise RSP → IDLE.
- Arbitration:
  - Data wins over instruction.
  - Exception: streak_cnt counts consecutive data grants issued while instr_req_i was high.
  - When streak_cnt == MAX_DATA_STREAK and instr_req_i is high, instruction wins and streak_cnt clears.
  - streak_cnt also clears on any instruction grant, or whenever instr_req_i is low.
  - streak_cnt saturates and never wraps.
- In ADDR:
  - mem_req_o = 1.
  - mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o come from the owner.
  - Instruction owner drives mem_we_o = 0, mem_be_o = 4'hF and mem_wdata_o = 0.
  - mem_gnt_i is routed combinationally to the owner's gnt_o. The non-owner's gnt_o is 0.
- In RSP:
  - mem_rvalid_i, mem_rdata_i and mem_err_i are routed combinationally to the owner's rvalid/rdata/err outputs.
  - The non-owner's rvalid_o is 0.
  - Stores also receive an rvalid.
- Watchdog:
  - wd_cnt clears on entry to RSP and increments every cycle in RSP.
  - At wd_cnt == TIMEOUT-1 without mem_rvalid_i, the owner gets rvalid = 1, err = 1 and rdata = 0 for one cycle, and the FSM leaves RSP.
- mem_rvalid_i outside RSP is ignored; this covers late responses after a timeout or reset.
- rdata outputs are 0 when the matching rvalid is 0.

## Timing
- Reset values:
  - State IDLE, owner = data, streak_cnt = 0, wd_cnt = 0.
  - All *_gnt_o, *_rvalid_o, *_err_o, mem_req_o, mem_we_o = 0.
  - mem_be_o = 0, address/data outputs = 0.
- Reset mid-transaction: the FSM returns to IDLE the next cycle with no response to the owner. The master is reset by the same rst_i.
- Minimum latency, req high to rvalid, with a zero-wait slave (gnt in ADDR's first cycle, rvalid on the next cycle): 3 cycles.
  - Cycle 0: IDLE sees req.
  - Cycle 1: ADDR, gnt.
  - Cycle 2: RSP, rvalid.
- Back-to-back throughput: one transaction per 2 cycles, via RSP → ADDR.
- Simultaneous instr_req_i and data_req_i in IDLE: data is granted first, and instruction follows after the response.
- A master must not deassert req or change address/data before gnt. Behaviour is undefined if it does.
- mem_gnt_i arriving together with a late mem_rvalid_i of the previous transaction is impossible by protocol (one outstanding); it needs no handling.

## Structure
- Shared package (jedro_1_defines):
  - arb_state_t enum {ARB_IDLE, ARB_ADDR, ARB_RSP}.
  - arb_owner_t enum {OWNER_INSTR, OWNER_DATA}.
  - MEM_BE_WIDTH = 4.
- One natural sub-module: jedro_1_arb_watchdog (wd_cnt, clear/enable, timeout pulse).
- Everything else is inline: FSM, streak counter, request/response muxes.

## Test plan
- Single fetch: instr_req_i = 1, addr 0x100; slave grants immediately and returns 0xDEADBEEF next cycle → instr_gnt_o at cycle 1, instr_rvalid_o with rdata 0xDEADBEEF at cycle 2, data side silent.
- Contention: both requests in the same cycle, store 0x0000_00AA to 0x200 with be 4'b0001 → mem sees the store first (we = 1, be = 0001), then fetch; each master receives exactly one rvalid.
- Starvation: data_req_i held high continuously, instr_req_i high, MAX_DATA_STREAK = 4 → exactly 4 data grants, then 1 instruction grant, then data resumes.
- Timeout: slave grants but never asserts rvalid, TIMEOUT = 64 → owner gets rvalid = 1, err = 1, rdata = 0 in the 64th RSP cycle; a later spurious mem_rvalid_i produces no output.
- Bus error: mem_err_i = 1 with rvalid on a load → data_err_o = 1 with data_rvalid_o for one cycle, and the FSM proceeds normally.
- Reset in RSP: assert rst_i for one cycle while a load waits → next cycle all outputs are at reset values, and a subsequent mem_rvalid_i is ignored.
